// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-byte adder: one shared 8-bit ripple adder, LSB byte first, carry chained through a flop.
// Optional subtract mode is compiled in with `define MBA_SUB_EN (adds the sub port).

module ripple_carry_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[8];
endmodule

module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef MBA_SUB_EN
    input  logic                  sub,
`endif
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, next_state;
    logic            accept;
    logic [W-1:0]    a_lat, b_lat;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [7:0]      add_a, add_b, add_s;
    logic            add_co;
`ifdef MBA_SUB_EN
    logic            sub_lat;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // start is honoured in DONE as well as IDLE so back-to-back ops lose no cycle
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) next_state = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign add_a = a_lat[8*idx +: 8];
`ifdef MBA_SUB_EN
    assign add_b = b_lat[8*idx +: 8] ^ {8{sub_lat}};
`else
    assign add_b = b_lat[8*idx +: 8];
`endif

    ripple_carry_adder_8bit u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_lat <= '0;
            b_lat <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef MBA_SUB_EN
            sub_lat <= 1'b0;
`endif
        end else if (accept) begin
            a_lat <= a;
            b_lat <= b;
            idx   <= '0;
`ifdef MBA_SUB_EN
            sub_lat <= sub;
            carry   <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
        end else if (state == RUN) begin
            sum[8*idx +: 8] <= add_s;
            carry           <= add_co;
            if (idx == LAST) begin
                cout <= add_co;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer (NBYTES=4) against an arithmetic reference model.
// Subtract checks are included when MBA_SUB_EN is defined.

module tb_multibyte_add_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MBA_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
`ifdef MBA_SUB_EN
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
`else
        r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        if (s) r = r;
`endif
        return r;
    endfunction

    // Issues one op from idle and waits (bounded) for done; returns to the caller at the done negedge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s, output int lat, output int busy_cnt);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({sum, cout, busy, done} !== {{W{1'b0}}, 3'b000}) begin
            miscompares++;
            $display("FAIL reset: sum=%h cout=%b busy=%b done=%b, want all zero", sum, cout, busy, done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] xa [3] = '{32'h0000004A, 32'h12345678, 32'hFFFFFFFF};
        logic [W-1:0] xb [3] = '{32'h0000005B, 32'h9ABCDEF0, 32'h00000000};
        logic         xc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   want [3] = '{33'h0_000000A5, 33'h0_ACF13568, 33'h1_00000000};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(xa[i], xb[i], xc[i], 1'b0, lat, bc);
            vectors++;
            if ({cout, sum} !== want[i]) begin
                miscompares++;
                $display("FAIL directed%0d: got cout=%b sum=%h want %h", i, cout, sum, want[i]);
            end
            vectors++;
            if (lat != NB + 1 || bc != NB) begin
                miscompares++;
                $display("FAIL latency%0d: done after %0d cycles busy %0d, want %0d/%0d", i, lat, bc, NB + 1, NB);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || {cout, sum} !== want[i]) begin
                miscompares++;
                $display("FAIL done_pulse%0d: done=%b sum=%h, want done=0 and held result %h", i, done, sum, want[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] x, y;
        logic c, s;
        logic [W:0] want;
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            if (i % 4 == 0) y = ~x;
`ifdef MBA_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            want = model(x, y, c, s);
            run_op(x, y, c, s, lat, bc);
            vectors++;
            if (lat >= 20 || {cout, sum} !== want) begin
                miscompares++;
                $display("FAIL random%0d: a=%h b=%h cin=%b sub=%b got %b_%h want %h lat=%0d",
                         i, x, y, c, s, cout, sum, want, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x0 = 32'h0F0F00FF, y0 = 32'h01010001;
        logic [W-1:0] x1 = 32'h80000000, y1 = 32'h80000001;
        logic [W:0] w0 = model(x0, y0, 1'b1, 1'b0);
        logic [W:0] w1 = model(x1, y1, 1'b0, 1'b0);
        int n;
        @(negedge clk);
        a = x0; b = y0; cin = 1'b1; sub = 1'b0; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end while (!done && n < 20);
        vectors++;
        if (n != NB + 1 || {cout, sum} !== w0) begin
            miscompares++;
            $display("FAIL hold_start: got %b_%h after %0d want %h after %0d", cout, sum, n, w0, NB + 1);
        end
        // start still high in the DONE cycle: this op begins at once
        a = x1; b = y1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != NB + 1 || {cout, sum} !== w1) begin
            miscompares++;
            $display("FAIL b2b_result: got %b_%h after %0d want %h after %0d", cout, sum, n, w1, NB + 1);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (sum[7:0] !== 8'h33 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_byte0: sum[7:0]=%h busy=%b want 33/1", sum[7:0], busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: busy=%b sum=%h cout=%b want 0/0/0", busy, sum, cout);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: done seen %0d times want 0", seen);
        end
        run_op(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, lat, bc);
        vectors++;
        if ({cout, sum} !== 33'h1_00000000 || lat != NB + 1) begin
            miscompares++;
            $display("FAIL after_abort: got %b_%h lat %0d want 1_00000000 lat %0d", cout, sum, lat, NB + 1);
        end
    endtask

`ifdef MBA_SUB_EN
    task automatic test_sub();
        int lat, bc;
        run_op(32'd7, 32'd5, 1'b0, 1'b1, lat, bc);
        vectors++;
        if ({cout, sum} !== 33'h1_00000002) begin
            miscompares++;
            $display("FAIL sub_7_5: got %b_%h want 1_00000002", cout, sum);
        end
        run_op(32'd5, 32'd7, 1'b1, 1'b1, lat, bc);
        vectors++;
        if ({cout, sum} !== 33'h0_FFFFFFFE) begin
            miscompares++;
            $display("FAIL sub_5_7: got %b_%h want 0_FFFFFFFE", cout, sum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef MBA_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
